// File: rtl/tcp_tx_bench_client_if.sv
// rtl/tcp_tx_bench_client_if.sv - tx metadata/status/data channels between client and network stack
interface tcp_tx_bench_client_if #(
    parameter int DATA_W = 512
) ();
    localparam int KEEP_W = DATA_W / 8;

    logic              meta_valid;
    logic              meta_ready;
    logic [31:0]       meta_data;
    logic              sts_valid;
    logic              sts_ready;
    logic [63:0]       sts_data;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data_data;
    logic [KEEP_W-1:0] data_keep;
    logic              data_last;

    modport master (
        output meta_valid, meta_data,
        input  meta_ready,
        input  sts_valid, sts_data,
        output sts_ready,
        output data_valid, data_data, data_keep, data_last,
        input  data_ready
    );

    modport slave (
        input  meta_valid, meta_data,
        output meta_ready,
        output sts_valid, sts_data,
        input  sts_ready,
        input  data_valid, data_data, data_keep, data_last,
        output data_ready
    );
endinterface

// File: rtl/tcp_tx_bench_client.sv
// rtl/tcp_tx_bench_client.sv - sends a burst of fixed-size TCP packets on one session and counts throughput
module tcp_tx_bench_client #(
    parameter int DATA_W    = 512,
    parameter int BACKOFF   = 64,
    parameter int MAX_RETRY = 255
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [15:0]           session_id,
    input  logic [15:0]           pkt_len,
    input  logic [31:0]           num_pkts,
    tcp_tx_bench_client_if.master tx,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           pkts_sent,
    output logic [63:0]           bytes_sent,
    output logic [63:0]           run_cycles
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int LANES  = DATA_W / 32;

    typedef enum logic [2:0] {S_IDLE, S_META, S_STS, S_DATA, S_BACKOFF, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic [15:0] session_q, session_d, len_q, len_d, rem_q, rem_d;
    logic [31:0] num_q, num_d, pkts_q, pkts_d, beat_idx_q, beat_idx_d;
    logic [31:0] retry_q, retry_d, bo_cnt_q, bo_cnt_d;
    logic [63:0] bytes_q, bytes_d, cyc_q, cyc_d;
    logic        error_q, error_d, zdone_q, zdone_d;

    logic        meta_hs, sts_hs, data_hs, last_beat, last_pkt;
    logic [2:0]  sts_err;
    logic        unused_sts;

    assign meta_hs    = (state_q == S_META) && tx.meta_ready;
    assign sts_hs     = (state_q == S_STS) && tx.sts_valid;
    assign data_hs    = (state_q == S_DATA) && tx.data_ready;
    assign last_beat  = rem_q <= 16'(KEEP_W);
    assign last_pkt   = (pkts_q + 32'd1) >= num_q;
    assign sts_err    = tx.sts_data[63:61];
    assign unused_sts = ^tx.sts_data[60:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            session_q  <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            num_q      <= '0;
            pkts_q     <= '0;
            beat_idx_q <= '0;
            retry_q    <= '0;
            bo_cnt_q   <= '0;
            bytes_q    <= '0;
            cyc_q      <= '0;
            error_q    <= 1'b0;
            zdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            session_q  <= session_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            num_q      <= num_d;
            pkts_q     <= pkts_d;
            beat_idx_q <= beat_idx_d;
            retry_q    <= retry_d;
            bo_cnt_q   <= bo_cnt_d;
            bytes_q    <= bytes_d;
            cyc_q      <= cyc_d;
            error_q    <= error_d;
            zdone_q    <= zdone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        session_d  = session_q;
        len_d      = len_q;
        rem_d      = rem_q;
        num_d      = num_q;
        pkts_d     = pkts_q;
        beat_idx_d = beat_idx_q;
        retry_d    = retry_q;
        bo_cnt_d   = bo_cnt_q;
        bytes_d    = bytes_q;
        cyc_d      = (state_q != S_IDLE) ? cyc_q + 64'd1 : cyc_q;
        error_d    = error_q;
        zdone_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    session_d  = session_id;
                    len_d      = pkt_len;
                    num_d      = num_pkts;
                    pkts_d     = '0;
                    bytes_d    = '0;
                    cyc_d      = '0;
                    beat_idx_d = '0;
                    retry_d    = '0;
                    error_d    = 1'b0;
                    if (pkt_len == 16'd0 || num_pkts == 32'd0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = S_META;
                    end
                end
            end
            S_META: begin
                if (meta_hs) state_d = S_STS;
            end
            S_STS: begin
                if (sts_hs) begin
                    if (sts_err == 3'd0) begin
                        state_d = S_DATA;
                        retry_d = '0;
                        rem_d   = len_q;
                    end else if (sts_err == 3'd1 && (retry_q + 32'd1) <= 32'(MAX_RETRY)) begin
                        state_d  = S_BACKOFF;
                        retry_d  = retry_q + 32'd1;
                        bo_cnt_d = '0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_BACKOFF: begin
                if (bo_cnt_q == 32'(BACKOFF - 1)) state_d = S_META;
                else bo_cnt_d = bo_cnt_q + 32'd1;
            end
            S_DATA: begin
                if (data_hs) begin
                    beat_idx_d = beat_idx_q + 32'd1;
                    rem_d      = rem_q - 16'(KEEP_W);
                    if (last_beat) begin
                        pkts_d  = pkts_q + 32'd1;
                        bytes_d = bytes_q + 64'(len_q);
                        state_d = last_pkt ? S_IDLE : S_META;
                    end
                end
            end
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output is gated by state so an asynchronous reset drops them all at once.
    always_comb begin
        tx.meta_valid = (state_q == S_META);
        tx.meta_data  = tx.meta_valid ? {len_q, session_q} : 32'd0;
        tx.sts_ready  = (state_q == S_STS);
        tx.data_valid = (state_q == S_DATA);
        tx.data_data  = tx.data_valid ? {LANES{beat_idx_q}} : '0;
        tx.data_last  = tx.data_valid && last_beat;
        for (int i = 0; i < KEEP_W; i++) begin
            tx.data_keep[i] = tx.data_valid && (rem_q > 16'(i));
        end
        busy       = (state_q != S_IDLE);
        done       = zdone_q || (state_q == S_ERROR) || (data_hs && last_beat && last_pkt);
        error      = error_q;
        pkts_sent  = pkts_q;
        bytes_sent = bytes_q;
        run_cycles = cyc_q;
    end
endmodule

// File: tb/tb_tcp_tx_bench_client.sv
// tb/tb_tcp_tx_bench_client.sv - self-checking bench for tcp_tx_bench_client
module tb_tcp_tx_bench_client;
    localparam int DATA_W    = 512;
    localparam int KEEP_W    = 64;
    localparam int LANES     = 16;
    localparam int BACKOFF   = 8;
    localparam int MAX_RETRY = 2;

    typedef struct {
        logic [15:0] sess;
        logic [15:0] len;
        logic [31:0] num;
        bit          bp;
        int          err_first;
        bit          always_err;
        logic [31:0] exp_pkts;
        logic [63:0] exp_bytes;
        int          exp_meta;
        logic        exp_error;
        logic [63:0] exp_cycles;
    } vec_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] session_id = '0;
    logic [15:0] pkt_len = '0;
    logic [31:0] num_pkts = '0;
    logic        busy, done, error;
    logic [31:0] pkts_sent;
    logic [63:0] bytes_sent, run_cycles;

    tcp_tx_bench_client_if #(.DATA_W(DATA_W)) tx ();

    tcp_tx_bench_client #(.DATA_W(DATA_W), .BACKOFF(BACKOFF), .MAX_RETRY(MAX_RETRY)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .session_id (session_id),
        .pkt_len    (pkt_len),
        .num_pkts   (num_pkts),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pkts_sent  (pkts_sent),
        .bytes_sent (bytes_sent),
        .run_cycles (run_cycles)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passes = 0;

    bit          bp_en, always_err, hold_data, start_next;
    int          err_left;
    logic [15:0] cur_len, cur_sess;
    int          meta_cnt, done_cnt, rem, gap_cnt;
    bit          gap_on;
    logic [31:0] exp_beat;
    bit          meta_hold, data_hold;
    logic [31:0] prev_meta, prev_lane0;
    logic [63:0] prev_keep;
    logic        prev_last;
    vec_t        vecs[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic observe();
        logic [63:0]       ek;
        logic [DATA_W-1:0] ed;
        if (gap_on && tx.meta_valid) begin
            check("backoff_gap", 64'(gap_cnt), 64'(BACKOFF));
            gap_on = 1'b0;
        end else if (gap_on) begin
            gap_cnt++;
        end
        if (meta_hold) begin
            check("meta_valid_held", 64'(tx.meta_valid), 64'd1);
            check("meta_data_held", 64'(tx.meta_data), 64'(prev_meta));
        end
        meta_hold = tx.meta_valid && !tx.meta_ready;
        prev_meta = tx.meta_data;
        if (tx.meta_valid && tx.meta_ready) begin
            meta_cnt++;
            check("meta_data", 64'(tx.meta_data), 64'({cur_len, cur_sess}));
            rem = int'(cur_len);
        end
        if (tx.sts_valid && tx.sts_ready) begin
            if (tx.sts_data[63:61] == 3'd1 && !always_err) begin
                gap_on  = 1'b1;
                gap_cnt = 0;
            end
            if (err_left > 0) err_left--;
        end
        if (data_hold) begin
            check("data_valid_held", 64'(tx.data_valid), 64'd1);
            check("data_held", 64'(tx.data_data[31:0]), 64'(prev_lane0));
            check("keep_held", 64'(tx.data_keep), prev_keep);
            check("last_held", 64'(tx.data_last), 64'(prev_last));
        end
        data_hold  = tx.data_valid && !tx.data_ready;
        prev_lane0 = tx.data_data[31:0];
        prev_keep  = tx.data_keep;
        prev_last  = tx.data_last;
        if (tx.data_valid && tx.data_ready) begin
            ek = (rem >= KEEP_W) ? '1 : ((64'd1 << rem) - 64'd1);
            ed = {LANES{exp_beat}};
            check("data_lane0", 64'(tx.data_data[31:0]), 64'(exp_beat));
            check("data_all_lanes", 64'(tx.data_data == ed), 64'd1);
            check("keep", 64'(tx.data_keep), ek);
            check("last", 64'(tx.data_last), 64'(rem <= KEEP_W));
            exp_beat++;
            rem -= KEEP_W;
        end
        check("one_channel", 64'(32'(tx.meta_valid) + 32'(tx.sts_ready) + 32'(tx.data_valid) <= 32'd1), 64'd1);
        if (done) done_cnt++;
    endtask

    task automatic cycle();
        @(negedge aclk);
        start         = start_next;
        start_next    = 1'b0;
        tx.meta_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        tx.data_ready = hold_data ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
        tx.sts_valid  = 1'b1;
        tx.sts_data   = {((err_left > 0) || always_err) ? 3'd1 : 3'd0, 29'd1000, 16'd0, 16'd0};
        #1;
        observe();
    endtask

    task automatic run_case(input vec_t v);
        cur_len    = v.len;
        cur_sess   = v.sess;
        bp_en      = v.bp;
        err_left   = v.err_first;
        always_err = v.always_err;
        meta_cnt   = 0;
        done_cnt   = 0;
        exp_beat   = 0;
        gap_on     = 1'b0;
        session_id = v.sess;
        pkt_len    = v.len;
        num_pkts   = v.num;
        start_next = 1'b1;
        cycle();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) cycle();
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) cycle();
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("meta_count", 64'(meta_cnt), 64'(v.exp_meta));
        check("pkts_sent", 64'(pkts_sent), 64'(v.exp_pkts));
        check("bytes_sent", bytes_sent, v.exp_bytes);
        check("error", 64'(error), 64'(v.exp_error));
        check("busy_after", 64'(busy), 64'd0);
        if (v.exp_cycles != 0) check("run_cycles", run_cycles, v.exp_cycles);
    endtask

    initial begin
        tx.meta_ready = 1'b0;
        tx.sts_valid  = 1'b0;
        tx.sts_data   = '0;
        tx.data_ready = 1'b0;
        bp_en = 0; always_err = 0; hold_data = 0; start_next = 0; err_left = 0;
        meta_hold = 0; data_hold = 0; gap_on = 0; rem = 0; exp_beat = 0;
        cur_len = 0; cur_sess = 0;

        //            sess      len     num bp err aerr pkts bytes meta err cycles
        vecs[0] = '{16'h0011, 16'd64,  32'd4, 0, 0, 0, 32'd4, 64'd256, 4, 1'b0, 64'd12};
        vecs[1] = '{16'h0022, 16'd100, 32'd1, 0, 0, 0, 32'd1, 64'd100, 1, 1'b0, 64'd4};
        vecs[2] = '{16'h0033, 16'd64,  32'd1, 0, 1, 0, 32'd1, 64'd64,  2, 1'b0, 64'd13};
        vecs[3] = '{16'h0044, 16'd64,  32'd2, 0, 0, 1, 32'd0, 64'd0,   3, 1'b1, 64'd23};
        vecs[4] = '{16'h0055, 16'd64,  32'd4, 1, 0, 0, 32'd4, 64'd256, 4, 1'b0, 64'd0};
        vecs[5] = '{16'h0066, 16'd130, 32'd3, 1, 0, 0, 32'd3, 64'd390, 3, 1'b0, 64'd0};
        vecs[6] = '{16'h0077, 16'd1,   32'd2, 0, 0, 0, 32'd2, 64'd2,   2, 1'b0, 64'd6};

        repeat (2) @(negedge aclk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_pkts", 64'(pkts_sent), 64'd0);
        check("rst_bytes", bytes_sent, 64'd0);
        check("rst_cycles", run_cycles, 64'd0);
        check("rst_meta_valid", 64'(tx.meta_valid), 64'd0);
        check("rst_sts_ready", 64'(tx.sts_ready), 64'd0);
        check("rst_data_valid", 64'(tx.data_valid), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 7; i++) run_case(vecs[i]);

        // Stall inside DATA, then hit reset while valid is up.
        hold_data  = 1'b1;
        bp_en      = 1'b0;
        err_left   = 0;
        always_err = 1'b0;
        cur_len    = 16'd64;
        cur_sess   = 16'h0088;
        exp_beat   = 0;
        session_id = 16'h0088;
        pkt_len    = 16'd64;
        num_pkts   = 32'd1;
        start_next = 1'b1;
        cycle();
        for (int i = 0; i < 20 && !tx.data_valid; i++) cycle();
        check("stalled_in_data", 64'(tx.data_valid), 64'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_data_valid", 64'(tx.data_valid), 64'd0);
        check("midrst_data", 64'(tx.data_data[31:0]), 64'd0);
        check("midrst_keep", 64'(tx.data_keep), 64'd0);
        check("midrst_last", 64'(tx.data_last), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cycles", run_cycles, 64'd0);
        check("midrst_error", 64'(error), 64'd0);
        meta_hold = 1'b0;
        data_hold = 1'b0;
        hold_data = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        run_case(vecs[0]);

        // Zero packet count completes without leaving IDLE.
        done_cnt   = 0;
        pkt_len    = 16'd64;
        num_pkts   = 32'd0;
        start_next = 1'b1;
        cycle();
        check("zero_done_early", 64'(done), 64'd0);
        cycle();
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_pkts", 64'(pkts_sent), 64'd0);
        check("zero_bytes", bytes_sent, 64'd0);
        check("zero_cycles", run_cycles, 64'd0);
        cycle();
        check("zero_done_clear", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
